cpu_core: RTL and testbench



---
 rtl/cpu_core.sv | 193 +++++++++++++++++++
 tb/tb_cpu_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// cpu_core: parametrised single-cycle CPU with register file, ALU, jump/branch
// and a two-state (RUN/MEM) data-memory handshake.
//
// Ports:
//   CLK            rising-edge clock
//   RESET          asynchronous active-low reset
//   INSTRUCTION    instruction at PC: OP=[31:24] D=[23:16] S1=[15:8] S2=[7:0]
//   PC             program counter (registered)
//   MEM_READ       data-memory read request (registered)
//   MEM_WRITE      data-memory write request (registered)
//   MEM_ADDR       data-memory address (registered)
//   MEM_WRITEDATA  store data (registered)
//   MEM_READDATA   load data, valid while MEM_BUSYWAIT is low
//   MEM_BUSYWAIT   memory busy; holds the core while in MEM
//
// Build option: define CPU_EXT_OPS_EN to enable bne (0x0C), sll (0x0D) and
// srl (0x0E); otherwise those opcodes behave as NOP.
module cpu_core #(
    parameter int unsigned     DATA_W     = 8,
    parameter int unsigned     REG_ADDR_W = 3,
    parameter int unsigned     PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       INSTRUCTION,
    output logic [PC_W-1:0]   PC,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    localparam int unsigned NREG = 1 << REG_ADDR_W;

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_MEM = 1'b1;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;
`ifdef CPU_EXT_OPS_EN
    localparam logic [7:0] OP_BNE   = 8'h0C;
    localparam logic [7:0] OP_SLL   = 8'h0D;
    localparam logic [7:0] OP_SRL   = 8'h0E;
`endif

    // Instruction fields
    logic [7:0]            op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [DATA_W-1:0]     imm;
    logic [PC_W-1:0]       off;
    logic                  unused_s1_hi;

    assign op           = INSTRUCTION[31:24];
    assign rd           = INSTRUCTION[16 +: REG_ADDR_W];
    assign rs1          = INSTRUCTION[8 +: REG_ADDR_W];
    assign rs2          = INSTRUCTION[0 +: REG_ADDR_W];
    assign imm          = DATA_W'(INSTRUCTION[7:0]);
    assign off          = PC_W'($signed(INSTRUCTION[23:16]));
    assign unused_s1_hi = ^INSTRUCTION[15:8];

    // State and register file
    logic [0:0]        state;
    logic [0:0]        state_next;
    logic [DATA_W-1:0] regs [NREG];

    // Combinational register reads; a same-cycle write is seen next cycle
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    assign rdata1 = regs[rs1];
    assign rdata2 = regs[rs2];

    // ALU: subtract as addition of the two's complement
    logic [DATA_W-1:0] alu_sum;
    logic [DATA_W-1:0] alu_diff;
    logic              alu_zero;
    assign alu_sum  = rdata1 + rdata2;
    assign alu_diff = rdata1 + (~rdata2 + DATA_W'(1));
    assign alu_zero = (alu_diff == '0);

    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] pc_target;
    assign pc_plus4  = PC + PC_W'(4);
    assign pc_target = pc_plus4 + (off << 2);

    // Next-state values
    logic [PC_W-1:0]   pc_next;
    logic              mem_read_next;
    logic              mem_write_next;
    logic [DATA_W-1:0] mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_next;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wdata;

    // Next-state, register-write and bus decode
    always_comb begin
        state_next     = state;
        pc_next        = PC;
        mem_read_next  = MEM_READ;
        mem_write_next = MEM_WRITE;
        mem_addr_next  = MEM_ADDR;
        mem_wdata_next = MEM_WRITEDATA;
        reg_we         = 1'b0;
        reg_wdata      = '0;

        case (state)
            ST_RUN: begin
                pc_next = pc_plus4;
                case (op)
                    OP_LOADI: begin reg_we = 1'b1; reg_wdata = imm;             end
                    OP_MOV:   begin reg_we = 1'b1; reg_wdata = rdata2;          end
                    OP_ADD:   begin reg_we = 1'b1; reg_wdata = alu_sum;         end
                    OP_SUB:   begin reg_we = 1'b1; reg_wdata = alu_diff;        end
                    OP_AND:   begin reg_we = 1'b1; reg_wdata = rdata1 & rdata2; end
                    OP_OR:    begin reg_we = 1'b1; reg_wdata = rdata1 | rdata2; end
                    OP_J:     pc_next = pc_target;
                    OP_BEQ:   if (alu_zero) pc_next = pc_target;
`ifdef CPU_EXT_OPS_EN
                    OP_BNE:   if (!alu_zero) pc_next = pc_target;
                    OP_SLL:   begin reg_we = 1'b1; reg_wdata = rdata1 << INSTRUCTION[2:0]; end
                    OP_SRL:   begin reg_we = 1'b1; reg_wdata = rdata1 >> INSTRUCTION[2:0]; end
`endif
                    // Memory ops hold PC until the access completes
                    OP_LWD, OP_LWI, OP_SWD, OP_SWI: begin
                        pc_next        = PC;
                        state_next     = ST_MEM;
                        mem_addr_next  = (op == OP_LWD || op == OP_SWD) ? rdata2 : imm;
                        mem_read_next  = (op == OP_LWD || op == OP_LWI);
                        mem_write_next = (op == OP_SWD || op == OP_SWI);
                        if (op == OP_SWD || op == OP_SWI) mem_wdata_next = rdata1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (!MEM_BUSYWAIT) begin
                    if (MEM_READ) begin
                        reg_we    = 1'b1;
                        reg_wdata = MEM_READDATA;
                    end
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    pc_next        = pc_plus4;
                    state_next     = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // State, PC and bus output registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= ST_RUN;
            PC            <= RESET_PC;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDR      <= '0;
            MEM_WRITEDATA <= '0;
        end else begin
            state         <= state_next;
            PC            <= pc_next;
            MEM_READ      <= mem_read_next;
            MEM_WRITE     <= mem_write_next;
            MEM_ADDR      <= mem_addr_next;
            MEM_WRITEDATA <= mem_wdata_next;
        end
    end

    // Register file
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[rd] <= reg_wdata;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed scenarios followed by random
// instruction streams, compared against an instruction-level model.
module tb_cpu_core;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PC_W   = 32;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [31:0]       INSTRUCTION;
    logic [PC_W-1:0]   PC;
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [DATA_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WRITEDATA;
    logic [DATA_W-1:0] MEM_READDATA;
    logic              MEM_BUSYWAIT;

    cpu_core #(.DATA_W(DATA_W), .REG_ADDR_W(3), .PC_W(PC_W), .RESET_PC('0)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .PC(PC),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model state
    logic [PC_W-1:0] m_pc;
    logic [7:0]      m_reg [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0;
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    endtask

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    // Execute one instruction starting at a negedge; returns at a negedge.
    task automatic exec(input logic [31:0] i, input int busy, input logic [7:0] rdata);
        logic [7:0] op, d, s1, s2, a, b, addr;
        logic       taken, is_load;
        op = i[31:24]; d = i[23:16]; s1 = i[15:8]; s2 = i[7:0];
        a  = m_reg[s1[2:0]];
        b  = m_reg[s2[2:0]];
        taken = 1'b0;
        check("pc_fetch", PC, m_pc);
        INSTRUCTION  = i;
        MEM_BUSYWAIT = 1'($urandom_range(0, 1));
        MEM_READDATA = 8'($urandom);
        @(negedge CLK);
        if (op >= 8'h08 && op <= 8'h0B) begin
            is_load = (op <= 8'h09);
            addr    = (op == 8'h08 || op == 8'h0A) ? b : s2;
            for (int c = 0; c <= busy; c++) begin
                check("mem_read", MEM_READ, is_load);
                check("mem_write", MEM_WRITE, !is_load);
                check("mem_addr", MEM_ADDR, addr);
                if (!is_load) check("mem_wdata", MEM_WRITEDATA, a);
                check("pc_hold", PC, m_pc);
                if (c < busy) begin
                    MEM_BUSYWAIT = 1'b1;
                    MEM_READDATA = 8'($urandom);
                end else begin
                    MEM_BUSYWAIT = 1'b0;
                    MEM_READDATA = rdata;
                end
                @(negedge CLK);
            end
            check("mem_idle", {MEM_READ, MEM_WRITE}, 2'b00);
            if (is_load) m_reg[d[2:0]] = rdata;
        end else begin
            case (op)
                8'h00: m_reg[d[2:0]] = s2;
                8'h01: m_reg[d[2:0]] = b;
                8'h02: m_reg[d[2:0]] = a + b;
                8'h03: m_reg[d[2:0]] = a - b;
                8'h04: m_reg[d[2:0]] = a & b;
                8'h05: m_reg[d[2:0]] = a | b;
                8'h06: taken = 1'b1;
                8'h07: taken = (a == b);
`ifdef CPU_EXT_OPS_EN
                8'h0C: taken = (a != b);
                8'h0D: m_reg[d[2:0]] = a << s2[2:0];
                8'h0E: m_reg[d[2:0]] = a >> s2[2:0];
`endif
                default: ;
            endcase
        end
        m_pc = m_pc + 32'd4 + (taken ? {{22{d[7]}}, d, 2'b00} : 32'd0);
        check("pc", PC, m_pc);
    endtask

    initial begin
        logic [7:0] rop;
        RESET        = 1'b1;
        INSTRUCTION  = '0;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        #1 RESET = 1'b0;
        #1;
        check("rst_pc", PC, 32'h0);
        check("rst_rdwr", {MEM_READ, MEM_WRITE}, 2'b00);
        check("rst_addr", MEM_ADDR, 8'h00);
        check("rst_wdata", MEM_WRITEDATA, 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        model_reset();

        // Reset mid-cycle after a few instructions
        exec(ins(8'h00, 8'h01, 8'h00, 8'h33), 0, 8'h00);
        exec(ins(8'h00, 8'h02, 8'h00, 8'h44), 0, 8'h00);
        exec(ins(8'h02, 8'h03, 8'h01, 8'h02), 0, 8'h00);
        #2 RESET = 1'b0;
        #1;
        check("midrst_pc", PC, 32'h0);
        check("midrst_rdwr", {MEM_READ, MEM_WRITE}, 2'b00);
        @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        exec(ins(8'h0B, 8'h00, 8'h01, 8'h10), 0, 8'h00);

        // ALU with wrap-around
        exec(ins(8'h00, 8'h01, 8'h00, 8'h05), 0, 8'h00);
        exec(ins(8'h00, 8'h02, 8'h00, 8'h03), 0, 8'h00);
        exec(ins(8'h03, 8'h03, 8'h01, 8'h02), 0, 8'h00);
        exec(ins(8'h03, 8'h04, 8'h02, 8'h01), 0, 8'h00);
        exec(ins(8'h00, 8'h05, 8'h00, 8'hFF), 0, 8'h00);
        exec(ins(8'h02, 8'h06, 8'h05, 8'h01), 0, 8'h00);
        exec(ins(8'h0B, 8'h00, 8'h03, 8'hA0), 0, 8'h00);
        check("sub_pos", MEM_WRITEDATA, 8'h02);
        exec(ins(8'h0B, 8'h00, 8'h04, 8'hA1), 1, 8'h00);
        check("sub_neg", MEM_WRITEDATA, 8'hFE);
        exec(ins(8'h0B, 8'h00, 8'h06, 8'hA2), 0, 8'h00);
        check("add_wrap", MEM_WRITEDATA, 8'h04);

        // Jump, taken/not-taken branch (r1=5, r2=3, r6=4)
        exec(ins(8'h06, 8'h02, 8'h00, 8'h00), 0, 8'h00);
        exec(ins(8'h07, 8'hFE, 8'h01, 8'h01), 0, 8'h00);
        exec(ins(8'h07, 8'hFE, 8'h01, 8'h02), 0, 8'h00);

        // Load with 3 busy cycles, then read the loaded register back
        exec(ins(8'h00, 8'h02, 8'h00, 8'h40), 0, 8'h00);
        exec(ins(8'h08, 8'h07, 8'h00, 8'h02), 3, 8'hA5);
        exec(ins(8'h0A, 8'h00, 8'h07, 8'h02), 0, 8'h00);
        check("load_val", MEM_WRITEDATA, 8'hA5);

        // Store without wait
        exec(ins(8'h0B, 8'h00, 8'h01, 8'h80), 0, 8'h00);

        // Reset during a stalled store
        INSTRUCTION  = ins(8'h0B, 8'h00, 8'h01, 8'h90);
        MEM_BUSYWAIT = 1'b1;
        @(negedge CLK);
        check("abort_wr", MEM_WRITE, 1'b1);
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        check("abort_wr_drop", MEM_WRITE, 1'b0);
        check("abort_pc", PC, 32'h0);
        @(negedge CLK);
        RESET        = 1'b1;
        MEM_BUSYWAIT = 1'b0;
        model_reset();
        exec(ins(8'h0B, 8'h00, 8'h01, 8'h91), 0, 8'h00);

        // Extended ops (NOP when not built in)
        exec(ins(8'h00, 8'h01, 8'h00, 8'h05), 0, 8'h00);
        exec(ins(8'h00, 8'h04, 8'h00, 8'h77), 0, 8'h00);
        exec(ins(8'h0D, 8'h04, 8'h01, 8'h02), 0, 8'h00);
        exec(ins(8'h0B, 8'h00, 8'h04, 8'h20), 0, 8'h00);
        exec(ins(8'h0E, 8'h04, 8'h01, 8'h01), 0, 8'h00);
        exec(ins(8'h0C, 8'h03, 8'h01, 8'h04), 0, 8'h00);
        exec(ins(8'h0B, 8'h00, 8'h04, 8'h21), 0, 8'h00);

        // Random instruction stream
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) rop = 8'($urandom);
            else                           rop = 8'($urandom_range(0, 14));
            exec(ins(rop, 8'($urandom), 8'($urandom), 8'($urandom)),
                 int'($urandom_range(0, 3)), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
